// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants, FSM states and error bit indices for the packet register
package router_pkg;

  localparam int CHK_XOR = 0;
  localparam int CHK_CRC = 1;

  localparam int ERR_CHK = 0;
  localparam int ERR_LEN = 1;

  localparam logic [7:0] CRC_POLY_DEF = 8'h07;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    CHKWAIT = 2'd2,
    DONE    = 2'd3
  } pkt_state_e;

endpackage

// File: rtl/router_chk_step.sv
// rtl/router_chk_step.sv - one-byte XOR parity or MSB-first CRC update, purely combinational
module router_chk_step
  import router_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter int                 CHK_MODE = CHK_XOR,
  parameter logic [DATA_W-1:0]  CRC_POLY = DATA_W'(CRC_POLY_DEF)
) (
  input  logic [DATA_W-1:0] calc,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] nxt
);

  // CRC: the byte is xored into the register up front, then shifted out one bit at a time
  always_comb begin
    nxt = calc ^ din;
    if (CHK_MODE == CHK_CRC) begin
      for (int i = 0; i < DATA_W; i++) begin
        nxt = nxt[DATA_W-1] ? ((nxt << 1) ^ CRC_POLY) : (nxt << 1);
      end
    end
  end

endmodule

// File: rtl/router_pkt_reg_p.sv
// rtl/router_pkt_reg_p.sv - router packet register: header latch, payload pass-through, full-FIFO replay, check and length error reporting
module router_pkt_reg_p
  import router_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 2,
  parameter int                 NPORTS   = 3,
  parameter int                 CHK_MODE = CHK_XOR,
  parameter logic [DATA_W-1:0]  CRC_POLY = DATA_W'(CRC_POLY_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_add,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              hdr_reject
);

  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int CNT_W = LEN_W + 1;

  logic [DATA_W-1:0] header_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] calc_q;
  logic [DATA_W-1:0] pkt_chk_q;
  logic [CNT_W-1:0]  count_q;
  pkt_state_e        state_q;
  pkt_state_e        state_d;
  logic              done_seen_q;

  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_ok;
  logic              hdr_latch;
  logic              hdr_bad;
  logic              fold_data;
  logic              chk_cap;
  logic              pd_set;
  logic              eval_now;
  logic [DATA_W-1:0] step_in;
  logic [DATA_W-1:0] calc_nxt;

  assign hdr_addr  = data_in[ADDR_W-1:0];
  assign hdr_ok    = int'(hdr_addr) < NPORTS;
  assign hdr_latch = detect_add & pkt_valid & hdr_ok;
  assign hdr_bad   = detect_add & pkt_valid & ~hdr_ok;
  assign fold_data = ld_state & pkt_valid & ~full_state;
  assign chk_cap   = ld_state & ~pkt_valid;
  assign pd_set    = (ld_state & ~fifo_full & ~pkt_valid) |
                     (laf_state & low_pkt_valid & ~parity_done);
  assign eval_now  = (state_q == DONE) & ~done_seen_q;
  assign step_in   = lfd_state ? header_q : data_in;
  assign err       = |err_code;

  router_chk_step #(
    .DATA_W   (DATA_W),
    .CHK_MODE (CHK_MODE),
    .CRC_POLY (CRC_POLY)
  ) u_chk_step (
    .calc (calc_q),
    .din  (step_in),
    .nxt  (calc_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      header_q   <= '0;
      hold_q     <= '0;
      dout       <= '0;
      hdr_reject <= 1'b0;
    end else begin
      hdr_reject <= hdr_bad;
      if (hdr_latch) header_q <= data_in;
      if (ld_state & fifo_full) hold_q <= data_in;
      if (lfd_state)                   dout <= header_q;
      else if (ld_state & ~fifo_full)  dout <= data_in;
      else if (laf_state)              dout <= hold_q;
    end
  end

  // The counter saturates so an over-long packet still reads as a length mismatch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calc_q    <= '0;
      count_q   <= '0;
      pkt_chk_q <= '0;
    end else begin
      if (hdr_latch) begin
        calc_q  <= '0;
        count_q <= '0;
      end else if (lfd_state) begin
        calc_q <= calc_nxt;
      end else if (fold_data) begin
        calc_q <= calc_nxt;
        if (count_q != '1) count_q <= count_q + CNT_W'(1);
      end
      if (chk_cap) pkt_chk_q <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_pkt_valid <= 1'b0;
      parity_done   <= 1'b0;
    end else begin
      if (rst_int_reg) low_pkt_valid <= 1'b0;
      if (chk_cap)     low_pkt_valid <= 1'b1;
      if (detect_add)  parity_done   <= 1'b0;
      if (pd_set)      parity_done   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_seen_q <= (state_q == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hdr_latch)   state_d = ACCUM;
      ACCUM:   if (chk_cap)     state_d = CHKWAIT;
      CHKWAIT: if (parity_done) state_d = DONE;
      DONE:    if (detect_add)  state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
    if (hdr_latch) state_d = ACCUM;
  end

  // Errors are sampled once, one cycle into DONE, and held until the next header
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_code <= 2'b00;
    end else begin
      if (eval_now) begin
        err_code[ERR_CHK] <= (calc_q != pkt_chk_q);
        err_code[ERR_LEN] <= (count_q != {1'b0, header_q[DATA_W-1:ADDR_W]});
      end
      if (detect_add) err_code <= 2'b00;
    end
  end

endmodule

// File: tb/tb_router_pkt_reg_p.sv
// tb/tb_router_pkt_reg_p.sv - scoreboard bench for router_pkt_reg_p in XOR and CRC modes
module tb_router_pkt_reg_p;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0, fifo_full = 1'b0, rst_int_reg = 1'b0, detect_add = 1'b0;
  logic       ld_state = 1'b0, laf_state = 1'b0, full_state = 1'b0, lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] x_dout, c_dout;
  logic       x_pd, x_lpv, x_err, x_hr, c_pd, c_lpv, c_err, c_hr;
  logic [1:0] x_ec, c_ec;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic       expect_out = 1'b0;
  logic       pend = 1'b0;
  logic [7:0] hdr_m = 8'h00, hold_m = 8'h00, last_m = 8'h00;
  logic [7:0] crc_v;

  always #5 clk = ~clk;

  router_pkt_reg_p #(.DATA_W(8), .ADDR_W(2), .NPORTS(3), .CHK_MODE(CHK_XOR), .CRC_POLY(8'h07)) dut_x (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .data_in(data_in), .dout(x_dout), .parity_done(x_pd), .low_pkt_valid(x_lpv),
    .err(x_err), .err_code(x_ec), .hdr_reject(x_hr));

  router_pkt_reg_p #(.DATA_W(8), .ADDR_W(2), .NPORTS(3), .CHK_MODE(CHK_CRC), .CRC_POLY(8'h07)) dut_c (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
    .data_in(data_in), .dout(c_dout), .parity_done(c_pd), .low_pkt_valid(c_lpv),
    .err(c_err), .err_code(c_ec), .hdr_reject(c_hr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC-8 reference, MSB first, init 0
  function automatic logic [7:0] crc8_ref(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0]  c = 8'h00;
    logic [15:0] msg = {b0, b1};
    logic        fb;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ msg[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  always @(posedge clk) pend <= expect_out;

  always @(negedge clk) begin
    logic [7:0] e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("dout_x", 32'(x_dout), 32'(e));
        chk("dout_c", 32'(c_dout), 32'(e));
      end
    end
  end

  task automatic drive(input logic da, lf, ld, la, fs, pv, ff, rir, input logic [7:0] d);
    @(negedge clk);
    detect_add = da; lfd_state = lf; ld_state = ld; laf_state = la;
    full_state = fs; pkt_valid = pv; fifo_full = ff; rst_int_reg = rir; data_in = d;
    expect_out = lf | (ld & ~ff) | la;
    if (lf) begin
      exp_q.push_back(hdr_m); last_m = hdr_m;
    end else if (ld & ~ff) begin
      exp_q.push_back(d); last_m = d;
    end else if (la) begin
      exp_q.push_back(hold_m); last_m = hold_m;
    end
    if (da & pv & (d[1:0] < 2'd3)) hdr_m = d;
    if (ld & ff) hold_m = d;
  endtask

  task automatic idle(input logic rir);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rir, 8'h00);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] p0, p1, p2, chkb);
    logic [7:0] p [3];
    p[0] = p0; p[1] = p1; p[2] = p2;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, hdr);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p0);
    #1;
    chk("pd_clr_on_hdr", 32'(x_pd), 32'd0);
    chk("err_clr_on_hdr", 32'(x_err), 32'd0);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, p[i]);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, chkb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_x", 32'({x_dout, x_pd, x_lpv, x_err, x_ec, x_hr}), 32'd0);
    chk("rst_out_c", 32'({c_dout, c_pd, c_lpv, c_err, c_ec, c_hr}), 32'd0);
    chk("rst_state", 32'(dut_x.state_q), 32'(IDLE));
    reset = 1'b0;

    // XOR good packet
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0D);
    idle(1'b0); #1;
    chk("good_pd", 32'(x_pd), 32'd1);
    chk("good_lpv", 32'(x_lpv), 32'd1);
    idle(1'b0); #1;
    chk("good_err_lat", 32'(x_err), 32'd0);
    chk("good_state", 32'(dut_x.state_q), 32'(DONE));
    idle(1'b0); #1;
    chk("good_err", 32'(x_err), 32'd0);
    chk("good_ec", 32'(x_ec), 32'd0);

    // XOR bad check byte
    send_pkt(8'h0D, 3, 8'h11, 8'h22, 8'h33, 8'h0C);
    idle(1'b0); idle(1'b0); #1;
    chk("badchk_err_lat", 32'(x_err), 32'd0);
    idle(1'b0); #1;
    chk("badchk_err", 32'(x_err), 32'd1);
    chk("badchk_ec", 32'(x_ec), 32'd1);
    idle(1'b1); idle(1'b0); #1;
    chk("badchk_hold", 32'(x_ec), 32'd1);
    chk("lpv_clr", 32'(x_lpv), 32'd0);

    // Length mismatch, XOR check correct
    send_pkt(8'h0D, 2, 8'h11, 8'h22, 8'h00, 8'h3E);
    idle(1'b0); idle(1'b0); idle(1'b0); #1;
    chk("len_ec", 32'(x_ec), 32'd2);
    chk("len_err", 32'(x_err), 32'd1);

    // Rejected header address
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03);
    idle(1'b0); #1;
    chk("rej_pulse", 32'(x_hr), 32'd1);
    chk("rej_hdr", 32'(dut_x.header_q), 32'(hdr_m));
    chk("rej_dout", 32'(x_dout), 32'(last_m));
    chk("rej_state", 32'(dut_x.state_q), 32'(IDLE));
    idle(1'b0); #1;
    chk("rej_pulse_end", 32'(x_hr), 32'd0);
    chk("rej_state2", 32'(dut_x.state_q), 32'(IDLE));

    // FIFO-full replay of payload byte 22
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0D);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33);
    #1;
    chk("replay_hold", 32'(dut_x.hold_q), 32'h22);
    chk("replay_dout_held", 32'(x_dout), 32'h11);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D);
    idle(1'b0); idle(1'b0); idle(1'b0); #1;
    chk("replay_pd", 32'(x_pd), 32'd1);
    chk("replay_ec", 32'(x_ec), 32'd0);

    // CRC-8 packet
    crc_v = crc8_ref(8'h05, 8'hA5);
    send_pkt(8'h05, 1, 8'hA5, 8'h00, 8'h00, crc_v);
    idle(1'b0); idle(1'b0); idle(1'b0); #1;
    chk("crc_pd", 32'(c_pd), 32'd1);
    chk("crc_ec", 32'(c_ec), 32'd0);
    chk("crc_err", 32'(c_err), 32'd0);

    // Reset in the middle of a packet
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h09);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44);
    idle(1'b0); #1;
    chk("mid_state", 32'(dut_c.state_q), 32'(ACCUM));
    #1 reset = 1'b1;
    hdr_m = 8'h00; hold_m = 8'h00;
    #1;
    chk("midrst_out_x", 32'({x_dout, x_pd, x_lpv, x_err, x_ec, x_hr}), 32'd0);
    chk("midrst_out_c", 32'({c_dout, c_pd, c_lpv, c_err, c_ec, c_hr}), 32'd0);
    chk("midrst_state", 32'(dut_c.state_q), 32'(IDLE));
    chk("midrst_hdr", 32'(dut_c.header_q), 32'd0);
    idle(1'b0);
    reset = 1'b0;
    idle(1'b0); #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
